// File: rtl/inst_fetch.sv
// PC / instruction-fetch stage: owns the PC, issues one fetch at a time on an
// SRAM-like req/addr_ok/data_ok port and hands pc/inst/valid to IF/ID.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [31:0] new_pc,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o,
  output logic        inst_adel_o,
  output logic        stallreq_from_pc
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] req_addr_q, req_addr_d;
  logic [AW-1:0] old_addr_q, old_addr_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [DW-1:0] inst_q, inst_d;
  logic          kill_q, kill_d;
  logic          valid_q, valid_d;
  logic          adel_q, adel_d;

  logic [AW-1:0] issue_addr;
  logic          issue_aligned;
  logic          stall_unused;

  // A request already visible to memory keeps its old address until accepted.
  assign issue_addr    = (state_q == ST_REQ && kill_q) ? old_addr_q : req_addr_q;
  assign issue_aligned = (issue_addr[1:0] == 2'b00);
  assign stall_unused  = ^stall[5:1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_REQ;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_REQ: begin
        if (!issue_aligned) begin
          state_d = flush ? ST_REQ : ST_HOLD;
        end else if (inst_addr_ok) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (inst_data_ok) begin
          state_d = (kill_q || flush) ? ST_REQ : ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (flush || !stall[0]) begin
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_REQ;
    endcase
  end

  always_comb begin
    inst_req         = 1'b0;
    inst_addr        = issue_addr;
    stallreq_from_pc = (state_q != ST_HOLD);
    if (!rst && state_q == ST_REQ && issue_aligned) begin
      inst_req = 1'b1;
    end
  end

  // Fetch address, kill bookkeeping and the IF/ID holding registers.
  always_comb begin
    req_addr_d = req_addr_q;
    old_addr_d = old_addr_q;
    kill_d     = kill_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    valid_d    = valid_q;
    adel_d     = adel_q;
    case (state_q)
      ST_REQ: begin
        if (!issue_aligned) begin
          if (!flush) begin
            pc_d    = req_addr_q;
            inst_d  = '0;
            valid_d = 1'b1;
            adel_d  = 1'b1;
          end
        end else if (flush) begin
          kill_d = 1'b1;
          if (!kill_q) begin
            old_addr_d = req_addr_q;
          end
        end
      end
      ST_WAIT: begin
        if (inst_data_ok) begin
          kill_d = 1'b0;
          if (!kill_q && !flush) begin
            pc_d    = req_addr_q;
            inst_d  = inst_rdata;
            valid_d = 1'b1;
            adel_d  = 1'b0;
          end
        end else if (flush) begin
          kill_d = 1'b1;
        end
      end
      ST_HOLD: begin
        if (!flush && !stall[0]) begin
          req_addr_d = branch_flag_i ? branch_target_i : pc_q + AW'(4);
          valid_d    = 1'b0;
          adel_d     = 1'b0;
        end
      end
      default: ;
    endcase
    if (flush) begin
      req_addr_d = new_pc;
      valid_d    = 1'b0;
      adel_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_addr_q <= RESET_PC;
      old_addr_q <= RESET_PC;
      kill_q     <= 1'b0;
      pc_q       <= RESET_PC;
      inst_q     <= '0;
      valid_q    <= 1'b0;
      adel_q     <= 1'b0;
    end else begin
      req_addr_q <= req_addr_d;
      old_addr_q <= old_addr_d;
      kill_q     <= kill_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      valid_q    <= valid_d;
      adel_q     <= adel_d;
    end
  end

  assign pc_o         = pc_q;
  assign inst_o       = inst_q;
  assign inst_valid_o = valid_q;
  assign inst_adel_o  = adel_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios followed by a randomized run against
// a transaction-level model of the expected fetch stream and a memory model.
module tb_inst_fetch;
  localparam logic [31:0] RESET_PC = 32'hbfc00000;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        inst_valid_o;
  logic        inst_adel_o;
  logic        stallreq_from_pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  inst_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .new_pc(new_pc),
    .branch_flag_i(branch_flag_i), .branch_target_i(branch_target_i),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata), .pc_o(pc_o),
    .inst_o(inst_o), .inst_valid_o(inst_valid_o), .inst_adel_o(inst_adel_o),
    .stallreq_from_pc(stallreq_from_pc)
  );

  // Memory contents: an injective function of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h13579bdf;
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = {16'hbfc0, 16'($urandom) & 16'hfffc};
    if ($urandom_range(0, 9) == 0) a[1:0] = 2'($urandom_range(1, 3));
    return a;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = '0; flush = 1'b0; new_pc = '0; branch_flag_i = 1'b0; branch_target_i = '0;
    inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = $urandom;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle();
    tick(); tick();
    checks++; if (inst_req !== 1'b0) begin errors++; $display("FAIL rst_req act=%b exp=0", inst_req); end
    checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid act=%b exp=0", inst_valid_o); end
    checks++; if (inst_adel_o !== 1'b0) begin errors++; $display("FAIL rst_adel act=%b exp=0", inst_adel_o); end
    checks++; if (pc_o !== RESET_PC) begin errors++; $display("FAIL rst_pc act=%h exp=%h", pc_o, RESET_PC); end
    checks++; if (inst_o !== 32'h0) begin errors++; $display("FAIL rst_inst act=%h exp=0", inst_o); end
    checks++; if (inst_addr !== RESET_PC) begin errors++; $display("FAIL rst_addr act=%h exp=%h", inst_addr, RESET_PC); end
    checks++; if (stallreq_from_pc !== 1'b1) begin errors++; $display("FAIL rst_stallreq act=%b exp=1", stallreq_from_pc); end
    rst = 1'b0; #1;
    checks++; if (inst_req !== 1'b1) begin errors++; $display("FAIL rst_release_req act=%b exp=1", inst_req); end
  endtask

  task automatic test_basic_fetch();
    inst_addr_ok = 1'b1; tick();
    inst_addr_ok = 1'b0;
    checks++; if (inst_req !== 1'b0 || stallreq_from_pc !== 1'b1) begin errors++; $display("FAIL t1_wait req=%b stallreq=%b exp 0/1", inst_req, stallreq_from_pc); end
    inst_data_ok = 1'b1; inst_rdata = 32'h24020001; tick();
    inst_data_ok = 1'b0; inst_rdata = $urandom;
    checks++; if (inst_valid_o !== 1'b1) begin errors++; $display("FAIL t1_valid act=%b exp=1", inst_valid_o); end
    checks++; if (pc_o !== 32'hbfc00000) begin errors++; $display("FAIL t1_pc act=%h exp=bfc00000", pc_o); end
    checks++; if (inst_o !== 32'h24020001) begin errors++; $display("FAIL t1_inst act=%h exp=24020001", inst_o); end
    checks++; if (stallreq_from_pc !== 1'b0 || inst_adel_o !== 1'b0 || inst_req !== 1'b0) begin errors++; $display("FAIL t1_hold stallreq=%b adel=%b req=%b exp 0/0/0", stallreq_from_pc, inst_adel_o, inst_req); end
    tick();
    checks++; if (inst_addr !== 32'hbfc00004 || inst_req !== 1'b1) begin errors++; $display("FAIL t1_next addr=%h req=%b exp bfc00004/1", inst_addr, inst_req); end
    checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL t1_valid_drop act=%b exp=0", inst_valid_o); end
  endtask

  task automatic test_stall_branch();
    inst_addr_ok = 1'b1; tick();
    inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h8c220000; tick();
    inst_data_ok = 1'b0;
    stall = {5'($urandom), 1'b1};
    for (int i = 0; i < 5; i++) begin
      branch_flag_i = 1'($urandom); branch_target_i = $urandom; inst_rdata = $urandom;
      tick();
      checks++; if (inst_valid_o !== 1'b1 || pc_o !== 32'hbfc00004 || inst_o !== 32'h8c220000 || inst_req !== 1'b0)
        begin errors++; $display("FAIL t2_frozen[%0d] valid=%b pc=%h inst=%h req=%b exp 1/bfc00004/8c220000/0", i, inst_valid_o, pc_o, inst_o, inst_req); end
    end
    stall = '0; branch_flag_i = 1'b1; branch_target_i = 32'hbfc00100; tick();
    branch_flag_i = 1'b0;
    checks++; if (inst_addr !== 32'hbfc00100 || inst_req !== 1'b1 || inst_valid_o !== 1'b0) begin errors++; $display("FAIL t2_branch addr=%h req=%b valid=%b exp bfc00100/1/0", inst_addr, inst_req, inst_valid_o); end
  endtask

  task automatic test_flush_wait();
    inst_addr_ok = 1'b1; tick();
    inst_addr_ok = 1'b0; flush = 1'b1; new_pc = 32'hbfc00380; tick();
    flush = 1'b0;
    checks++; if (inst_valid_o !== 1'b0 || inst_req !== 1'b0 || stallreq_from_pc !== 1'b1) begin errors++; $display("FAIL t3_kill valid=%b req=%b stallreq=%b exp 0/0/1", inst_valid_o, inst_req, stallreq_from_pc); end
    inst_data_ok = 1'b1; inst_rdata = 32'hdeadbeef; tick();
    inst_data_ok = 1'b0;
    checks++; if (inst_valid_o !== 1'b0 || inst_req !== 1'b1 || inst_addr !== 32'hbfc00380) begin errors++; $display("FAIL t3_drop valid=%b req=%b addr=%h exp 0/1/bfc00380", inst_valid_o, inst_req, inst_addr); end
    inst_addr_ok = 1'b1; tick();
    inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h11112222; tick();
    inst_data_ok = 1'b0;
    checks++; if (inst_valid_o !== 1'b1 || pc_o !== 32'hbfc00380 || inst_o !== 32'h11112222) begin errors++; $display("FAIL t3_refetch valid=%b pc=%h inst=%h exp 1/bfc00380/11112222", inst_valid_o, pc_o, inst_o); end
  endtask

  task automatic test_flush_req();
    tick();
    checks++; if (inst_req !== 1'b1 || inst_addr !== 32'hbfc00384) begin errors++; $display("FAIL t4_req req=%b addr=%h exp 1/bfc00384", inst_req, inst_addr); end
    flush = 1'b1; new_pc = 32'hbfc00380; tick();
    flush = 1'b0;
    checks++; if (inst_req !== 1'b1 || inst_addr !== 32'hbfc00384) begin errors++; $display("FAIL t4_hold_old0 req=%b addr=%h exp 1/bfc00384", inst_req, inst_addr); end
    tick();
    checks++; if (inst_req !== 1'b1 || inst_addr !== 32'hbfc00384) begin errors++; $display("FAIL t4_hold_old1 req=%b addr=%h exp 1/bfc00384", inst_req, inst_addr); end
    inst_addr_ok = 1'b1; tick();
    inst_addr_ok = 1'b0;
    checks++; if (inst_req !== 1'b0) begin errors++; $display("FAIL t4_wait req=%b exp=0", inst_req); end
    inst_data_ok = 1'b1; inst_rdata = 32'hbad0bad0; tick();
    inst_data_ok = 1'b0;
    checks++; if (inst_valid_o !== 1'b0 || inst_req !== 1'b1 || inst_addr !== 32'hbfc00380) begin errors++; $display("FAIL t4_drop valid=%b req=%b addr=%h exp 0/1/bfc00380", inst_valid_o, inst_req, inst_addr); end
    inst_addr_ok = 1'b1; tick();
    inst_addr_ok = 1'b0; inst_data_ok = 1'b1; flush = 1'b1; new_pc = 32'hbfc00400; inst_rdata = 32'h33334444; tick();
    inst_data_ok = 1'b0; flush = 1'b0;
    checks++; if (inst_valid_o !== 1'b0 || inst_req !== 1'b1 || inst_addr !== 32'hbfc00400) begin errors++; $display("FAIL t4_flush_data valid=%b req=%b addr=%h exp 0/1/bfc00400", inst_valid_o, inst_req, inst_addr); end
    inst_addr_ok = 1'b1; tick();
    inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h55556666; tick();
    inst_data_ok = 1'b0;
    checks++; if (inst_valid_o !== 1'b1 || pc_o !== 32'hbfc00400 || inst_o !== 32'h55556666) begin errors++; $display("FAIL t4_fetch valid=%b pc=%h inst=%h exp 1/bfc00400/55556666", inst_valid_o, pc_o, inst_o); end
  endtask

  task automatic test_misaligned();
    branch_flag_i = 1'b1; branch_target_i = 32'hbfc00102; tick();
    branch_flag_i = 1'b0;
    checks++; if (inst_req !== 1'b0 || inst_addr !== 32'hbfc00102 || stallreq_from_pc !== 1'b1) begin errors++; $display("FAIL t5_noreq req=%b addr=%h stallreq=%b exp 0/bfc00102/1", inst_req, inst_addr, stallreq_from_pc); end
    stall = 6'b000001; inst_addr_ok = 1'b1; tick();
    inst_addr_ok = 1'b0;
    checks++; if (inst_valid_o !== 1'b1 || inst_adel_o !== 1'b1 || inst_o !== 32'h0 || pc_o !== 32'hbfc00102 || inst_req !== 1'b0)
      begin errors++; $display("FAIL t5_adel valid=%b adel=%b inst=%h pc=%h req=%b exp 1/1/0/bfc00102/0", inst_valid_o, inst_adel_o, inst_o, pc_o, inst_req); end
    flush = 1'b1; new_pc = 32'hbfc00200; tick();
    flush = 1'b0; stall = '0;
    checks++; if (inst_adel_o !== 1'b0 || inst_valid_o !== 1'b0 || inst_addr !== 32'hbfc00200 || inst_req !== 1'b1)
      begin errors++; $display("FAIL t5_clear adel=%b valid=%b addr=%h req=%b exp 0/0/bfc00200/1", inst_adel_o, inst_valid_o, inst_addr, inst_req); end
  endtask

  task automatic test_wrap();
    inst_addr_ok = 1'b1; flush = 1'b1; new_pc = 32'hfffffffc; tick();
    inst_addr_ok = 1'b0; flush = 1'b0;
    checks++; if (inst_req !== 1'b0 || stallreq_from_pc !== 1'b1) begin errors++; $display("FAIL wrap_kill req=%b stallreq=%b exp 0/1", inst_req, stallreq_from_pc); end
    inst_data_ok = 1'b1; inst_rdata = $urandom; tick();
    inst_data_ok = 1'b0;
    checks++; if (inst_addr !== 32'hfffffffc || inst_req !== 1'b1 || inst_valid_o !== 1'b0) begin errors++; $display("FAIL wrap_req addr=%h req=%b valid=%b exp fffffffc/1/0", inst_addr, inst_req, inst_valid_o); end
    inst_addr_ok = 1'b1; tick();
    inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h0badcafe; tick();
    inst_data_ok = 1'b0;
    checks++; if (inst_valid_o !== 1'b1 || pc_o !== 32'hfffffffc || inst_o !== 32'h0badcafe) begin errors++; $display("FAIL wrap_hold valid=%b pc=%h inst=%h exp 1/fffffffc/0badcafe", inst_valid_o, pc_o, inst_o); end
    tick();
    checks++; if (inst_addr !== 32'h0 || inst_req !== 1'b1) begin errors++; $display("FAIL wrap_next addr=%h req=%b exp 00000000/1", inst_addr, inst_req); end
  endtask

  task automatic test_reset_mid();
    inst_addr_ok = 1'b1; tick();
    inst_addr_ok = 1'b0; rst = 1'b1; #1;
    checks++; if (inst_req !== 1'b0) begin errors++; $display("FAIL t6_req_in_rst act=%b exp=0", inst_req); end
    tick();
    checks++; if (inst_req !== 1'b0 || inst_valid_o !== 1'b0 || stallreq_from_pc !== 1'b1 || pc_o !== RESET_PC)
      begin errors++; $display("FAIL t6_reset req=%b valid=%b stallreq=%b pc=%h exp 0/0/1/%h", inst_req, inst_valid_o, stallreq_from_pc, pc_o, RESET_PC); end
    rst = 1'b0; #1;
    checks++; if (inst_addr !== RESET_PC || inst_req !== 1'b1) begin errors++; $display("FAIL t6_release addr=%h req=%b exp %h/1", inst_addr, inst_req, RESET_PC); end
  endtask

  // Model: the address each delivered instruction must carry, plus a memory
  // that answers one accepted request after a random delay.
  task automatic test_random();
    logic [31:0] exp_next, last_pc, last_inst, exp_inst, out_addr, prev_addr;
    bit outstanding, prev_valid, prev_pend;
    int cnt, idle_cycles, deliveries;
    exp_next = RESET_PC; last_pc = RESET_PC; last_inst = '0; out_addr = '0; prev_addr = '0;
    outstanding = 1'b0; prev_valid = 1'b0; prev_pend = 1'b0;
    cnt = 0; idle_cycles = 0; deliveries = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      rst = ($urandom_range(0, 199) == 0);
      stall = 6'($urandom); stall[0] = ($urandom_range(0, 9) < 4);
      flush = ($urandom_range(0, 24) == 0); new_pc = rand_addr();
      branch_flag_i = 1'($urandom); branch_target_i = rand_addr();
      inst_addr_ok = ($urandom_range(0, 9) < 6);
      inst_data_ok = 1'b0; inst_rdata = $urandom;
      if (!rst && outstanding) begin
        if (cnt == 0) begin inst_data_ok = 1'b1; inst_rdata = mem_word(out_addr); end
        else cnt--;
      end
      #1;
      if (inst_valid_o && !prev_valid) begin
        deliveries++; idle_cycles = 0;
        exp_inst = (exp_next[1:0] == 2'b00) ? mem_word(exp_next) : 32'h0;
        checks++; if (pc_o !== exp_next) begin errors++; $display("FAIL rnd_pc cyc=%0d act=%h exp=%h", cyc, pc_o, exp_next); end
        checks++; if (inst_o !== exp_inst) begin errors++; $display("FAIL rnd_inst cyc=%0d act=%h exp=%h", cyc, inst_o, exp_inst); end
        checks++; if (inst_adel_o !== (exp_next[1:0] != 2'b00)) begin errors++; $display("FAIL rnd_adel cyc=%0d act=%b exp=%b", cyc, inst_adel_o, exp_next[1:0] != 2'b00); end
        last_pc = exp_next; last_inst = exp_inst;
      end else if (inst_valid_o) begin
        checks++; if (pc_o !== last_pc || inst_o !== last_inst) begin errors++; $display("FAIL rnd_frozen cyc=%0d pc=%h inst=%h exp %h/%h", cyc, pc_o, inst_o, last_pc, last_inst); end
      end else begin
        idle_cycles++;
      end
      checks++; if (stallreq_from_pc !== !inst_valid_o) begin errors++; $display("FAIL rnd_stallreq cyc=%0d act=%b exp=%b", cyc, stallreq_from_pc, !inst_valid_o); end
      checks++; if (inst_req && (rst || inst_valid_o || outstanding || inst_addr[1:0] != 2'b00))
        begin errors++; $display("FAIL rnd_req_legal cyc=%0d req=1 rst=%b valid=%b outstanding=%b addr=%h exp req=0", cyc, rst, inst_valid_o, outstanding, inst_addr); end
      if (prev_pend && !rst) begin
        checks++; if (inst_req !== 1'b1 || inst_addr !== prev_addr) begin errors++; $display("FAIL rnd_req_stable cyc=%0d req=%b addr=%h exp 1/%h", cyc, inst_req, inst_addr, prev_addr); end
      end
      if (idle_cycles > 300) begin
        checks++; errors++; $display("FAIL rnd_progress cyc=%0d idle=%0d exp<=300", cyc, idle_cycles);
        idle_cycles = 0;
      end
      prev_valid = inst_valid_o;
      if (rst) begin
        exp_next = RESET_PC; outstanding = 1'b0; prev_pend = 1'b0;
      end else begin
        if (inst_data_ok) outstanding = 1'b0;
        if (inst_req && inst_addr_ok) begin
          outstanding = 1'b1; out_addr = inst_addr; cnt = int'($urandom_range(0, 2));
        end
        prev_pend = inst_req && !inst_addr_ok; prev_addr = inst_addr;
        if (flush) exp_next = new_pc;
        else if (inst_valid_o && !stall[0]) exp_next = branch_flag_i ? branch_target_i : last_pc + 32'd4;
      end
    end
    checks++; if (deliveries < 50) begin errors++; $display("FAIL rnd_deliveries act=%0d exp>=50", deliveries); end
    rst = 1'b0; idle();
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_stall_branch();
    test_flush_wait();
    test_flush_req();
    test_misaligned();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
